// File: rtl/lane_deskew.sv
`default_nettype none
// ============================================================================
// Module   : lane_deskew
// Brief    : Four-lane receive deskew. Each lane is written into its own
//            circular buffer through a shared write pointer. Lanes are
//            aligned on the COM symbol with one read pointer per lane, and
//            the aligned bytes are presented with a valid flag. Alignment
//            losses are counted with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module lane_deskew #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] COM   = 8'hBC
) (
  input  logic       clk250k,
  input  logic       reset_L,
  input  logic [7:0] Lane_0,
  input  logic [7:0] Lane_1,
  input  logic [7:0] Lane_2,
  input  logic [7:0] Lane_3,
  output logic [7:0] Lane_0_out,
  output logic [7:0] Lane_1_out,
  output logic [7:0] Lane_2_out,
  output logic [7:0] Lane_3_out,
  output logic       valid_out,
  output logic       aligned,
  output logic [7:0] skew_err_cnt
);

  localparam int              c_LANES = 4;
  localparam int              c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_SEARCH  = 1'b0,
    ST_ALIGNED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [7:0]           w_lane_in  [c_LANES];
  logic [7:0]           w_rd_byte  [c_LANES];
  logic [7:0]           r_lane_out [c_LANES];
  logic [c_PW-1:0]      r_rp       [c_LANES];
  logic [c_PW-1:0]      r_com_ptr  [c_LANES];
  logic [c_PW-1:0]      r_wp;
  logic [c_PW-1:0]      r_win_cnt;
  logic [c_LANES-1:0]   r_flag;
  logic [c_LANES-1:0]   w_flag_next;
  logic [c_LANES-1:0]   w_com_hit;
  logic [c_LANES-1:0]   w_rd_com;
  logic                 w_timeout;
  logic                 w_all_set;
  logic                 w_misalign;
  logic                 r_valid;
  logic [7:0]           r_err_cnt;

  // Advance a buffer pointer with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_lane_in[0] = Lane_0;
  assign w_lane_in[1] = Lane_1;
  assign w_lane_in[2] = Lane_2;
  assign w_lane_in[3] = Lane_3;

  for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    // Every lane byte lands in the shared write slot, in every FSM state.
    always_ff @(posedge clk250k) begin
      r_mem[r_wp] <= w_lane_in[gi];
    end

    // Read happens before the same-edge write, so a skew of DEPTH-1 still
    // returns the oldest byte while its slot is being overwritten.
    assign w_rd_byte[gi] = r_mem[r_rp[gi]];
    assign w_rd_com[gi]  = (w_rd_byte[gi] == COM);
    assign w_com_hit[gi] = (w_lane_in[gi] == COM);
  end

  // Shared write pointer, free running.
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      r_wp <= '0;
    end else begin
      r_wp <= f_ptr_inc(r_wp);
    end
  end

  // State register.
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: COM search with timeout, then misalignment watch.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_all_set    = 1'b0;
    w_misalign   = 1'b0;
    w_flag_next  = r_flag;
    case (r_state)
      ST_SEARCH: begin
        // Timeout wins over any COM sampled on the same edge.
        w_timeout = (|r_flag) && !(&r_flag) && (r_win_cnt == c_LAST);
        if (!w_timeout) begin
          w_flag_next = r_flag | w_com_hit;
          w_all_set   = &w_flag_next;
          if (w_all_set) begin
            w_state_next = ST_ALIGNED;
          end
        end
      end
      ST_ALIGNED: begin
        w_misalign = (|w_rd_com) && !(&w_rd_com);
        if (w_misalign) begin
          w_state_next = ST_SEARCH;
        end
      end
      default: begin
        w_state_next = ST_SEARCH;
      end
    endcase
  end

  // COM flags, recorded COM slots, window counter and read pointers.
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      r_flag    <= '0;
      r_win_cnt <= '0;
      for (int i = 0; i < c_LANES; i++) begin
        r_rp[i]      <= '0;
        r_com_ptr[i] <= '0;
      end
    end else if (r_state == ST_SEARCH) begin
      if (w_timeout) begin
        r_flag    <= '0;
        r_win_cnt <= '0;
      end else if (w_all_set) begin
        // Lanes whose COM arrives on this edge start at the current slot.
        r_flag    <= '0;
        r_win_cnt <= '0;
        for (int i = 0; i < c_LANES; i++) begin
          r_rp[i] <= r_flag[i] ? r_com_ptr[i] : r_wp;
        end
      end else begin
        r_flag <= w_flag_next;
        for (int i = 0; i < c_LANES; i++) begin
          if (w_com_hit[i] && !r_flag[i]) begin
            r_com_ptr[i] <= r_wp;
          end
        end
        // Counter restarts at 0 on the first flag and runs while flags are partial.
        r_win_cnt <= (|r_flag) ? r_win_cnt + 1'b1 : '0;
      end
    end else begin
      for (int i = 0; i < c_LANES; i++) begin
        r_rp[i] <= f_ptr_inc(r_rp[i]);
      end
      if (w_misalign) begin
        r_flag    <= '0;
        r_win_cnt <= '0;
      end
    end
  end

  // Output lanes and valid: load while aligned, hold otherwise.
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      r_valid <= 1'b0;
      for (int i = 0; i < c_LANES; i++) begin
        r_lane_out[i] <= 8'h00;
      end
    end else if (r_state == ST_ALIGNED) begin
      r_valid <= !w_misalign;
      for (int i = 0; i < c_LANES; i++) begin
        r_lane_out[i] <= w_rd_byte[i];
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of alignment losses.
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      r_err_cnt <= 8'h00;
    end else if (w_misalign && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign Lane_0_out   = r_lane_out[0];
  assign Lane_1_out   = r_lane_out[1];
  assign Lane_2_out   = r_lane_out[2];
  assign Lane_3_out   = r_lane_out[3];
  assign valid_out    = r_valid;
  assign aligned      = (r_state == ST_ALIGNED);
  assign skew_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lane_deskew.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_deskew
// Brief    : Self-checking bench for lane_deskew. A timestamp-based reference
//            model keeps the full byte history of every lane and the absolute
//            sample time of each lane's COM, and predicts every output after
//            every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_deskew;

  localparam int         c_DEPTH = 4;
  localparam logic [7:0] c_COM   = 8'hBC;
  localparam int         c_HMAX  = 16384;

  logic       clk250k = 1'b0;
  logic       reset_L = 1'b1;
  logic [7:0] lane_in [4];
  logic [7:0] Lane_0_out, Lane_1_out, Lane_2_out, Lane_3_out;
  logic       valid_out, aligned;
  logic [7:0] skew_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] hist [4][c_HMAX];
  int         t = 0;
  bit         m_al;
  bit         m_flag [4];
  int         com_t [4];
  int         m_first;
  int         m_k;
  logic [7:0] m_out [4];
  bit         m_valid;
  logic [7:0] m_err;

  logic [7:0] lq [4][$];

  lane_deskew #(.DEPTH(c_DEPTH), .COM(c_COM)) dut (
    .clk250k      (clk250k),
    .reset_L      (reset_L),
    .Lane_0       (lane_in[0]),
    .Lane_1       (lane_in[1]),
    .Lane_2       (lane_in[2]),
    .Lane_3       (lane_in[3]),
    .Lane_0_out   (Lane_0_out),
    .Lane_1_out   (Lane_1_out),
    .Lane_2_out   (Lane_2_out),
    .Lane_3_out   (Lane_3_out),
    .valid_out    (valid_out),
    .aligned      (aligned),
    .skew_err_cnt (skew_err_cnt)
  );

  always #5 clk250k = ~clk250k;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rnd_nc();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == c_COM) v = 8'h00;
    return v;
  endfunction

  task automatic model_reset();
    m_al    = 1'b0;
    m_valid = 1'b0;
    m_err   = 8'h00;
    m_k     = 0;
    m_first = 0;
    for (int i = 0; i < 4; i++) begin
      m_flag[i] = 1'b0;
      m_out[i]  = 8'h00;
    end
  endtask

  task automatic model_step();
    int         nset;
    int         ncom;
    bit         any_new;
    logic [7:0] b;
    if (t >= c_HMAX) begin
      $display("FAIL hist: edge index %0d required below %0d", t, c_HMAX);
      $fatal(1, "history overflow");
    end
    for (int i = 0; i < 4; i++) hist[i][t] = lane_in[i];
    if (!m_al) begin
      m_valid = 1'b0;
      nset = 0;
      for (int i = 0; i < 4; i++) if (m_flag[i]) nset++;
      if (nset > 0 && nset < 4 && (t - m_first) == c_DEPTH) begin
        for (int i = 0; i < 4; i++) m_flag[i] = 1'b0;
      end else begin
        any_new = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!m_flag[i] && lane_in[i] == c_COM) begin
            m_flag[i] = 1'b1;
            com_t[i]  = t;
            any_new   = 1'b1;
          end
        end
        if (nset == 0 && any_new) m_first = t;
        if (m_flag[0] && m_flag[1] && m_flag[2] && m_flag[3]) begin
          m_al = 1'b1;
          m_k  = 0;
          for (int i = 0; i < 4; i++) m_flag[i] = 1'b0;
        end
      end
    end else begin
      ncom = 0;
      for (int i = 0; i < 4; i++) begin
        b = hist[i][com_t[i] + m_k];
        m_out[i] = b;
        if (b == c_COM) ncom++;
      end
      if (ncom > 0 && ncom < 4) begin
        m_valid = 1'b0;
        m_al    = 1'b0;
        if (m_err != 8'hFF) m_err = m_err + 8'h01;
      end else begin
        m_valid = 1'b1;
      end
      m_k++;
    end
    t++;
  endtask

  task automatic compare_all();
    chk("out0",    Lane_0_out,         m_out[0]);
    chk("out1",    Lane_1_out,         m_out[1]);
    chk("out2",    Lane_2_out,         m_out[2]);
    chk("out3",    Lane_3_out,         m_out[3]);
    chk("valid",   {7'b0, valid_out},  {7'b0, m_valid});
    chk("aligned", {7'b0, aligned},    {7'b0, m_al});
    chk("errcnt",  skew_err_cnt,       m_err);
  endtask

  // Drive one byte per lane, clock it in, advance the model and compare.
  task automatic cycle(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    lane_in[0] = b0;
    lane_in[1] = b1;
    lane_in[2] = b2;
    lane_in[3] = b3;
    @(posedge clk250k);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(rnd_nc(), rnd_nc(), rnd_nc(), rnd_nc());
  endtask

  task automatic flush();
    logic [7:0] b [4];
    while (lq[0].size() > 0 || lq[1].size() > 0 || lq[2].size() > 0 || lq[3].size() > 0) begin
      for (int i = 0; i < 4; i++) begin
        if (lq[i].size() > 0) b[i] = lq[i].pop_front();
        else                  b[i] = rnd_nc();
      end
      cycle(b[0], b[1], b[2], b[3]);
    end
  endtask

  // Per lane: skew fillers, COM, then a shared data sequence.
  task automatic frame(input int s0, input int s1, input int s2, input int s3,
                       input int len, input logic [7:0] base, input bit rnd);
    int         sk [4];
    logic [7:0] d [$];
    logic [7:0] v;
    sk = '{s0, s1, s2, s3};
    for (int n = 0; n < len; n++) begin
      if (rnd) v = rnd_nc();
      else begin
        v = base + 8'(n);
        if (v == c_COM) v = v + 8'd1;
      end
      d.push_back(v);
    end
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < sk[i]; s++) lq[i].push_back(rnd_nc());
      lq[i].push_back(c_COM);
      foreach (d[n]) begin
        v = d[n];
        if (rnd && $urandom_range(0, 39) == 0) v = c_COM;
        lq[i].push_back(v);
      end
    end
    flush();
  endtask

  // Assert reset between edges, check the asynchronous clear, hold over an edge.
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_out0",  Lane_0_out,        8'h00);
    chk("rst_out3",  Lane_3_out,        8'h00);
    chk("rst_valid", {7'b0, valid_out}, 8'h00);
    chk("rst_align", {7'b0, aligned},   8'h00);
    chk("rst_err",   skew_err_cnt,      8'h00);
    model_reset();
    @(posedge clk250k);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) lane_in[i] = 8'h00;
    model_reset();
    #1 reset_L = 1'b0;
    #1;
    chk("init_out1",  Lane_1_out,        8'h00);
    chk("init_out2",  Lane_2_out,        8'h00);
    chk("init_valid", {7'b0, valid_out}, 8'h00);
    chk("init_align", {7'b0, aligned},   8'h00);
    chk("init_err",   skew_err_cnt,      8'h00);
    @(posedge clk250k);
    @(posedge clk250k);
    #1 reset_L = 1'b1;
    idle(3);

    // Zero skew, explicit latency checks.
    cycle(c_COM, c_COM, c_COM, c_COM);
    chk("zs_align_n",  {7'b0, aligned},   8'd1);
    chk("zs_valid_n",  {7'b0, valid_out}, 8'd0);
    cycle(8'h01, 8'h01, 8'h01, 8'h01);
    chk("zs_valid_n1", {7'b0, valid_out}, 8'd1);
    chk("zs_out0_com", Lane_0_out,        c_COM);
    chk("zs_out3_com", Lane_3_out,        c_COM);
    cycle(8'h02, 8'h02, 8'h02, 8'h02);
    chk("zs_out2_01",  Lane_2_out,        8'h01);
    cycle(8'h03, 8'h03, 8'h03, 8'h03);
    chk("zs_out1_02",  Lane_1_out,        8'h02);
    chk("zs_err",      skew_err_cnt,      8'd0);

    // Skew 0/1/2/3, including the DEPTH-1 boundary.
    do_reset();
    idle(2);
    frame(0, 1, 2, 3, 6, 8'h10, 1'b0);
    chk("sk_align", {7'b0, aligned},   8'd1);
    chk("sk_valid", {7'b0, valid_out}, 8'd1);
    chk("sk_err",   skew_err_cnt,      8'd0);

    // Excess skew: lane 3 four cycles late.
    do_reset();
    idle(2);
    frame(0, 1, 2, 4, 4, 8'h20, 1'b0);
    idle(3);
    chk("xs_align", {7'b0, aligned},   8'd0);
    chk("xs_valid", {7'b0, valid_out}, 8'd0);
    chk("xs_err",   skew_err_cnt,      8'd0);

    // Timeout coincidence, then a clean set aligns.
    frame(0, 4, 4, 4, 3, 8'h30, 1'b0);
    idle(2);
    chk("tc_align", {7'b0, aligned}, 8'd0);
    frame(0, 0, 0, 0, 3, 8'h40, 1'b0);
    chk("tc_realign", {7'b0, aligned}, 8'd1);

    // Loss of alignment.
    cycle(c_COM, c_COM, c_COM, 8'h55);
    idle(1);
    chk("la_valid", {7'b0, valid_out}, 8'd0);
    chk("la_align", {7'b0, aligned},   8'd0);
    chk("la_err",   skew_err_cnt,      8'd1);
    idle(1);
    frame(0, 0, 0, 0, 2, 8'h50, 1'b0);
    chk("la_realign", {7'b0, aligned}, 8'd1);
    for (int n = 0; n < 300; n++) begin
      cycle(c_COM, c_COM, c_COM, 8'h55);
      idle(2);
      frame(0, 0, 0, 0, 1, 8'h60, 1'b0);
    end
    chk("la_sat",     skew_err_cnt,    8'hFF);
    chk("la_sat_aln", {7'b0, aligned}, 8'd1);

    // Reset mid-operation while aligned.
    do_reset();
    idle(4);
    chk("rm_align", {7'b0, aligned}, 8'd0);
    frame(0, 0, 0, 0, 2, 8'h70, 1'b0);
    chk("rm_realign", {7'b0, aligned}, 8'd1);

    // Randomized frames with random skews (some excessive) and stray COMs.
    for (int f = 0; f < 60; f++) begin
      frame($urandom_range(0, c_DEPTH), $urandom_range(0, c_DEPTH),
            $urandom_range(0, c_DEPTH), $urandom_range(0, c_DEPTH),
            $urandom_range(2, 10), 8'h00, 1'b1);
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lane_deskew.md
Name: lane_deskew

Overview:
- Receive-side lane-to-lane deskew stage that sits directly upstream of byte joining.
- Accepts four 8-bit lanes whose framing can be skewed by up to DEPTH-1 cycles.
- Aligns the lanes on the COM symbol and presents four mutually aligned lanes, plus a valid flag, to the byte-joining stage.
- Counts alignment losses.

Parameters:
- DEPTH, 4, per-lane circular buffer entries; legal 2..8; maximum tolerated skew = DEPTH-1 cycles.
- COM, 8'hBC, alignment symbol (K28.5 data byte).

Ports:
- clk250k  input  1  lane clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- Lane_0  input  8  raw lane 0 byte, one per clock.
- Lane_1  input  8  raw lane 1 byte.
- Lane_2  input  8  raw lane 2 byte.
- Lane_3  input  8  raw lane 3 byte.
- Lane_0_out  output  8  deskewed lane 0 (registered).
- Lane_1_out  output  8  deskewed lane 1.
- Lane_2_out  output  8  deskewed lane 2.
- Lane_3_out  output  8  deskewed lane 3.
- valid_out  output  1  Lane_x_out carry aligned data this cycle.
- aligned  output  1  high while the FSM is in ALIGNED.
- skew_err_cnt  output  8  saturating count of alignment losses.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - All Lane_x_out=8'h00; valid_out=0, aligned=0, skew_err_cnt=0.
  - Shared write pointer wp=0; all read pointers=0; COM flags cleared; window counter=0; FSM=SEARCH.
  - Buffer contents are don't-care.
  - Reset mid-operation discards all alignment; outputs drop on assertion, not on the next edge.
- Buffering: every edge, each Lane_i is written to buf_i[wp]; wp increments mod DEPTH. Buffers are written in every FSM state.
- SEARCH:
  - A lane sampling COM with its flag clear sets flag_i and records com_ptr_i=wp (that COM's write slot).
  - A COM on a lane whose flag is already set is ignored; the first COM is kept.
  - The first flag set (any lane) starts the window counter at 0; it increments every edge while any flag is set and not all are set.
  - All four flags set (including the same edge as the last COM): rp_i<=com_ptr_i, FSM->ALIGNED, aligned=1 after that edge.
  - Timeout: counter==DEPTH-1 and not all flags set.
    - All flags and the counter clear; stay in SEARCH.
    - A COM sampled on the timeout edge is discarded; timeout has priority.
    - The search restarts on the next edge.
- ALIGNED, every edge:
  - Lane_i_out<=buf_i[rp_i], read before the same-edge write; rp_i++ mod DEPTH; valid_out=1.
  - Latency: lanes are presented at the output one edge after the latest lane's COM is sampled; earlier lanes are delayed by their relative skew.
  - Skew of exactly DEPTH-1 is legal: the read of the oldest slot coincides with its overwrite and returns the old data.
- Misalignment check, on the bytes being loaded, buf_i[rp_i]:
  - Condition: at least one byte == COM but not all four == COM.
  - Outputs still load, valid_out=0, aligned=0, flags clear.
  - skew_err_cnt++ (saturates at 255); FSM->SEARCH.
  - The misaligned COMs are not reused for the new search; the search starts on the next sampled bytes.
- Outside ALIGNED, Lane_x_out hold their last value and valid_out=0.

Test Plan:
- Zero skew: reset, then COM on all lanes at the same edge N, then data 01,02,03… on every lane -> aligned=1 after edge N; valid_out=1 and all Lane_x_out=BC after edge N+1; the 01.. sequence follows in lockstep; skew_err_cnt=0.
- Skew 0/1/2/3 (DEPTH=4): lanes 0..3 delayed by 0..3 cycles, each lane's stream COM,10,11,12,… -> aligned one edge after lane 3's COM; next edge all outs=BC; following edges all=10, then 11; valid_out stays 1.
- Excess skew: lane 3 COM 4 cycles after lane 0 -> timeout at counter=3, flags clear, aligned stays 0, valid_out=0, skew_err_cnt=0; lane 3's late COM is discarded.
- Loss of alignment: after alignment, inject COM on lanes 0-2 only (lane 3 sends 8'h55) -> valid_out=0 and aligned=0 after the corresponding edge; skew_err_cnt=1; a re-sent aligned COM realigns; after 300 injections the counter reads 255.
- Reset mid-operation: assert reset_L=0 between edges while ALIGNED -> outputs immediately 0, aligned=0, count=0; after release, alignment requires a fresh COM on all lanes.
- Timeout coincidence: lane 0 COM, then the last COM on lanes 1-3 arrives on the timeout edge -> no alignment; search restarts; the next clean COM set aligns normally.
